// File: rtl/hazard_stall_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_unit_pkg
// Brief    : Shared types for the rv32i hazard/stall controller: register
//            index type, controller state encoding, counter width.
// Revision : 1.0  initial release
// ============================================================================
package hazard_stall_unit_pkg;

   // Architectural register index (x0..x31)
   typedef logic [4:0] rv32i_reg;

   // Controller states
   typedef enum logic [1:0] {
      RUN           = 2'd0,
      MEM_WAIT      = 2'd1,
      REDIRECT_WAIT = 2'd2
   } hazard_state_t;

   // Width of the performance counters
   localparam int PERF_CTR_WIDTH = 32;

endpackage
`default_nettype wire

// File: rtl/hazard_stall_unit_perf_counters.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_unit_perf_counters
// Brief    : Saturating stall-cycle and load-use bubble counters. Only
//            instantiated when HAZARD_PERF_CTR_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module hazard_stall_unit_perf_counters
   import hazard_stall_unit_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_stall,
   input  logic                      i_bubble,
   output logic [PERF_CTR_WIDTH-1:0] o_stall_cycles,
   output logic [PERF_CTR_WIDTH-1:0] o_bubble_count
);

   localparam logic [PERF_CTR_WIDTH-1:0] c_CTR_MAX = '1;

   logic [PERF_CTR_WIDTH-1:0] r_stall_cycles;
   logic [PERF_CTR_WIDTH-1:0] r_bubble_count;

   // Count stalled cycles and bubbles, holding at all-ones instead of wrapping
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cycles <= '0;
         r_bubble_count <= '0;
      end else begin
         if (i_stall && (r_stall_cycles != c_CTR_MAX))
            r_stall_cycles <= r_stall_cycles + 1'b1;
         if (i_bubble && (r_bubble_count != c_CTR_MAX))
            r_bubble_count <= r_bubble_count + 1'b1;
      end
   end

   assign o_stall_cycles = r_stall_cycles;
   assign o_bubble_count = r_bubble_count;

endmodule
`default_nettype wire

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_unit
// Brief    : Stall/flush controller for the 5-stage rv32i pipeline. Inserts
//            one bubble on load-use, freezes on outstanding I/D memory and
//            squashes wrong-path work on a taken branch/jump.
//            Optional: HAZARD_PERF_CTR_EN adds stall_cycles / bubble_count.
// Revision : 1.0  initial release
// ============================================================================
module hazard_stall_unit
   import hazard_stall_unit_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  rv32i_reg IFID_rs1,
   input  rv32i_reg IFID_rs2,
   input  logic     IFID_uses_rs1,
   input  logic     IFID_uses_rs2,
   input  rv32i_reg IDEX_rd,
   input  logic     IDEX_mem_read,
   input  logic     br_taken,
   input  logic     imem_read,
   input  logic     imem_resp,
   input  logic     dmem_read,
   input  logic     dmem_write,
   input  logic     dmem_resp,
   output logic     pc_load,
   output logic     IFID_load,
   output logic     IDEX_load,
   output logic     EXMEM_load,
   output logic     MEMWB_load,
   output logic     IFID_flush,
   output logic     IDEX_flush,
   output logic     stall
`ifdef HAZARD_PERF_CTR_EN
   ,
   output logic [PERF_CTR_WIDTH-1:0] stall_cycles,
   output logic [PERF_CTR_WIDTH-1:0] bubble_count
`endif
);

   hazard_state_t r_state;
   hazard_state_t w_state_nxt;
   logic          w_load_use;
   logic          w_imem_wait;
   logic          w_dmem_wait;
   logic          w_bubble;

   // x0 never creates a dependency; forwarding handles everything except a
   // load whose data is not back until the end of MEM.
   assign w_load_use  = IDEX_mem_read && (IDEX_rd != 5'd0) &&
                        ((IFID_uses_rs1 && (IFID_rs1 == IDEX_rd)) ||
                         (IFID_uses_rs2 && (IFID_rs2 == IDEX_rd)));
   assign w_imem_wait = imem_read && !imem_resp;
   assign w_dmem_wait = (dmem_read || dmem_write) && !dmem_resp;

   // State register; reset discards any pending redirect
   always_ff @(posedge clk) begin
      if (rst) r_state <= RUN;
      else     r_state <= w_state_nxt;
   end

   // Next state and pipeline control, all same-cycle combinational
   always_comb begin
      w_state_nxt = r_state;
      pc_load     = 1'b1;
      IFID_load   = 1'b1;
      IDEX_load   = 1'b1;
      EXMEM_load  = 1'b1;
      MEMWB_load  = 1'b1;
      IFID_flush  = 1'b0;
      IDEX_flush  = 1'b0;
      w_bubble    = 1'b0;
      if (rst) begin
         {pc_load, IFID_load, IDEX_load, EXMEM_load, MEMWB_load} = 5'b0;
         IFID_flush  = 1'b1;
         IDEX_flush  = 1'b1;
         w_state_nxt = RUN;
      end else if (r_state == REDIRECT_WAIT) begin
         // The branch target is already latched in PC; wait for the stale
         // fetch to return, then drop it and the wrong-path ID instruction.
         if (imem_resp && !w_dmem_wait) begin
            IFID_flush  = 1'b1;
            IDEX_flush  = 1'b1;
            w_state_nxt = RUN;
         end else begin
            {pc_load, IFID_load, IDEX_load, EXMEM_load, MEMWB_load} = 5'b0;
         end
      end else begin
         if (w_dmem_wait) begin
            {pc_load, IFID_load, IDEX_load, EXMEM_load, MEMWB_load} = 5'b0;
            w_state_nxt = MEM_WAIT;
         end else if (br_taken && w_imem_wait) begin
            // In-flight fetch cannot be aborted: remember the redirect
            {pc_load, IFID_load, IDEX_load, EXMEM_load, MEMWB_load} = 5'b0;
            w_state_nxt = REDIRECT_WAIT;
         end else if (w_imem_wait) begin
            {pc_load, IFID_load, IDEX_load, EXMEM_load, MEMWB_load} = 5'b0;
            w_state_nxt = MEM_WAIT;
         end else if (br_taken) begin
            // Squashed ID instruction makes any load-use moot
            IFID_flush  = 1'b1;
            IDEX_flush  = 1'b1;
            w_state_nxt = RUN;
         end else if (w_load_use) begin
            pc_load     = 1'b0;
            IFID_load   = 1'b0;
            IDEX_flush  = 1'b1;
            w_bubble    = 1'b1;
            w_state_nxt = RUN;
         end else begin
            w_state_nxt = RUN;
         end
      end
   end

   assign stall = !(pc_load && IFID_load && IDEX_load && EXMEM_load && MEMWB_load);

`ifdef HAZARD_PERF_CTR_EN
   hazard_stall_unit_perf_counters u_perf (
      .clk            (clk),
      .rst            (rst),
      .i_stall        (stall),
      .i_bubble       (w_bubble),
      .o_stall_cycles (stall_cycles),
      .o_bubble_count (bubble_count)
   );
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_stall_unit
// Brief    : Directed scoreboard bench for hazard_stall_unit. Counter checks
//            are active when HAZARD_PERF_CTR_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_stall_unit;
   import hazard_stall_unit_pkg::*;

   // {pc, IFID, IDEX, EXMEM, MEMWB load, IFID_flush, IDEX_flush, stall}
   localparam logic [7:0] c_ALL   = 8'b11111_00_0;
   localparam logic [7:0] c_HOLD  = 8'b00000_00_1;
   localparam logic [7:0] c_BUB   = 8'b00111_01_1;
   localparam logic [7:0] c_FLUSH = 8'b11111_11_0;
   localparam logic [7:0] c_RST   = 8'b00000_11_1;

   logic     clk = 1'b0;
   logic     rst;
   rv32i_reg IFID_rs1, IFID_rs2, IDEX_rd;
   logic     IFID_uses_rs1, IFID_uses_rs2, IDEX_mem_read, br_taken;
   logic     imem_read, imem_resp, dmem_read, dmem_write, dmem_resp;
   logic     pc_load, IFID_load, IDEX_load, EXMEM_load, MEMWB_load;
   logic     IFID_flush, IDEX_flush, stall;
`ifdef HAZARD_PERF_CTR_EN
   logic [31:0] stall_cycles, bubble_count;
`endif

   int errors = 0;
   int checks = 0;
   logic [7:0] r_sb_q[$];
   logic [31:0] exp_stall_cycles = 0;
   logic [31:0] exp_bubble_count = 0;

   hazard_stall_unit dut (
      .clk           (clk),
      .rst           (rst),
      .IFID_rs1      (IFID_rs1),
      .IFID_rs2      (IFID_rs2),
      .IFID_uses_rs1 (IFID_uses_rs1),
      .IFID_uses_rs2 (IFID_uses_rs2),
      .IDEX_rd       (IDEX_rd),
      .IDEX_mem_read (IDEX_mem_read),
      .br_taken      (br_taken),
      .imem_read     (imem_read),
      .imem_resp     (imem_resp),
      .dmem_read     (dmem_read),
      .dmem_write    (dmem_write),
      .dmem_resp     (dmem_resp),
      .pc_load       (pc_load),
      .IFID_load     (IFID_load),
      .IDEX_load     (IDEX_load),
      .EXMEM_load    (EXMEM_load),
      .MEMWB_load    (MEMWB_load),
      .IFID_flush    (IFID_flush),
      .IDEX_flush    (IDEX_flush),
      .stall         (stall)
`ifdef HAZARD_PERF_CTR_EN
      ,
      .stall_cycles  (stall_cycles),
      .bubble_count  (bubble_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic idle();
      rst = 1'b0; IFID_rs1 = 5'd0; IFID_rs2 = 5'd0; IFID_uses_rs1 = 1'b0;
      IFID_uses_rs2 = 1'b0; IDEX_rd = 5'd0; IDEX_mem_read = 1'b0; br_taken = 1'b0;
      imem_read = 1'b1; imem_resp = 1'b1; dmem_read = 1'b0; dmem_write = 1'b0;
      dmem_resp = 1'b0;
   endtask

   // lw x5 in EX, add x6,x1,x5 in ID
   task automatic set_load_use();
      IDEX_mem_read = 1'b1; IDEX_rd = 5'd5; IFID_rs1 = 5'd1; IFID_rs2 = 5'd5;
      IFID_uses_rs1 = 1'b1; IFID_uses_rs2 = 1'b1;
   endtask

   // Called just after a falling edge with inputs set: queue the expected
   // control word, sample before the rising edge, then move to next negedge.
   task automatic step(input string tag, input logic [7:0] exp);
      logic [7:0] e;
      r_sb_q.push_back(exp);
      if (rst) begin
         exp_stall_cycles = 0;
         exp_bubble_count = 0;
      end else begin
         if (exp[0]) exp_stall_cycles++;
         if (exp == c_BUB) exp_bubble_count++;
      end
      #2;
      e = r_sb_q.pop_front();
      check(tag, {24'd0, pc_load, IFID_load, IDEX_load, EXMEM_load, MEMWB_load,
                  IFID_flush, IDEX_flush, stall}, {24'd0, e});
      @(negedge clk);
   endtask

   task automatic check_ctrs(input string tag);
`ifdef HAZARD_PERF_CTR_EN
      check({tag, "_stall_cycles"}, stall_cycles, exp_stall_cycles);
      check({tag, "_bubble_count"}, bubble_count, exp_bubble_count);
`else
      if (tag.len() < 0) $display("%s", tag);
`endif
   endtask

   initial begin
      idle();
      rst = 1'b1;
      step("reset0", c_RST);
      step("reset1", c_RST);
      rst = 1'b0;
      check_ctrs("after_reset");
      step("idle", c_ALL);

      // Load-use on rs2: exactly one bubble, then flow
      set_load_use(); IFID_uses_rs1 = 1'b0;
      step("lu_rs2", c_BUB);
      idle();
      step("lu_rs2_after", c_ALL);
      // Destination x0 never stalls
      set_load_use(); IDEX_rd = 5'd0; IFID_rs2 = 5'd0;
      step("lu_x0", c_ALL);
      // Matching rs1 not actually read
      idle(); set_load_use(); IFID_rs1 = 5'd5; IFID_rs2 = 5'd7; IFID_uses_rs1 = 1'b0;
      step("lu_rs1_unused", c_ALL);
      IFID_uses_rs1 = 1'b1;
      step("lu_rs1", c_BUB);
      idle();
      // Not a load: forwarding covers it
      set_load_use(); IDEX_mem_read = 1'b0;
      step("no_load", c_ALL);
      idle();
      check_ctrs("load_use");

      // Store miss: 4 held cycles then advance on resp
      dmem_write = 1'b1;
      for (int i = 0; i < 4; i++) step("dmiss_hold", c_HOLD);
      dmem_resp = 1'b1;
      step("dmiss_resp", c_ALL);
      idle();
      check_ctrs("dmiss");

      // Branch beats a simultaneous load-use
      set_load_use(); br_taken = 1'b1;
      step("br_lu", c_FLUSH);
      idle();
      step("br_after", c_ALL);
      check_ctrs("branch");

      // Branch during fetch miss: 3 cycles of wait, flush on resp, then RUN
      br_taken = 1'b1; imem_resp = 1'b0;
      step("brmiss_0", c_HOLD);
      br_taken = 1'b0;
      step("brmiss_1", c_HOLD);
      step("brmiss_2", c_HOLD);
      imem_resp = 1'b1;
      step("brmiss_resp", c_FLUSH);
      step("brmiss_run", c_ALL);

      // Simultaneous waits: dmem answers 2 cycles before imem
      dmem_read = 1'b1; imem_resp = 1'b0;
      step("both_0", c_HOLD);
      step("both_1", c_HOLD);
      dmem_resp = 1'b1;
      step("both_dresp", c_HOLD);
      dmem_read = 1'b0; dmem_resp = 1'b0;
      step("both_3", c_HOLD);
      imem_resp = 1'b1;
      step("both_iresp", c_ALL);
      check_ctrs("waits");

      // Data wait outranks branch
      dmem_read = 1'b1; br_taken = 1'b1;
      step("br_dwait", c_HOLD);
      dmem_resp = 1'b1;
      step("br_dresp", c_FLUSH);
      idle();

      // Redirect whose fetch returns while dmem still waiting
      br_taken = 1'b1; imem_resp = 1'b0;
      step("rd_enter", c_HOLD);
      br_taken = 1'b0; imem_resp = 1'b1; dmem_read = 1'b1;
      step("rd_dwait", c_HOLD);
      dmem_read = 1'b0;
      step("rd_resp", c_FLUSH);
      step("rd_run", c_ALL);

      // Reset while in REDIRECT_WAIT drops the redirect
      br_taken = 1'b1; imem_resp = 1'b0;
      step("rst_enter", c_HOLD);
      br_taken = 1'b0; rst = 1'b1;
      step("rst_mid", c_RST);
      rst = 1'b0; imem_resp = 1'b1;
      step("rst_run", c_ALL);
      check_ctrs("rst_mid");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
